uart_baud_gen: RTL and testbench



---
 rtl/uart_baud_gen.sv | 137 +++++++++++++
 tb/tb_uart_baud_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_gen.sv
// UART bit-timing generator: preset or custom divisor, frame state machine with
// registered mid-bit sample tick, end-of-bit tick, bit index and frame-done pulse.
module uart_baud_gen #(
  parameter int CLK_FREQ   = 50000000,
  parameter int CNT_W      = 16,
  parameter int FRAME_BITS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             baud_start,
  input  logic [2:0]       baud_sel,
  input  logic [CNT_W-1:0] custom_div,
  output logic             mid_tick,
  output logic             bit_tick,
  output logic [3:0]       bit_idx,
  output logic             frame_done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] DIV_9600   = CNT_W'(CLK_FREQ / 9600 - 1);
  localparam logic [CNT_W-1:0] DIV_19200  = CNT_W'(CLK_FREQ / 19200 - 1);
  localparam logic [CNT_W-1:0] DIV_38400  = CNT_W'(CLK_FREQ / 38400 - 1);
  localparam logic [CNT_W-1:0] DIV_57600  = CNT_W'(CLK_FREQ / 57600 - 1);
  localparam logic [CNT_W-1:0] DIV_115200 = CNT_W'(CLK_FREQ / 115200 - 1);
  localparam logic [CNT_W-1:0] MIN_DIV    = CNT_W'(3);
  localparam logic [3:0]       LAST_BIT   = 4'(FRAME_BITS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cont_q, cont_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic             mid_tick_q, mid_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] sel_div;
  logic [CNT_W-1:0] half_div;
  logic             at_half;
  logic             at_end;

  // Divisor captured only on frame entry; selects 5 and 6 fall back to 9600.
  always_comb begin
    sel_div = DIV_9600;
    case (baud_sel)
      3'd1:    sel_div = DIV_19200;
      3'd2:    sel_div = DIV_38400;
      3'd3:    sel_div = DIV_57600;
      3'd4:    sel_div = DIV_115200;
      3'd7:    sel_div = (custom_div < MIN_DIV) ? MIN_DIV : custom_div;
      default: sel_div = DIV_9600;
    endcase
  end

  assign half_div = div_q >> 1;
  assign at_half  = (cont_q == half_div);
  assign at_end   = (cont_q == div_q);

  always_comb begin
    state_d      = state_q;
    cont_d       = cont_q;
    div_d        = div_q;
    bit_idx_d    = bit_idx_q;
    mid_tick_d   = 1'b0;
    bit_tick_d   = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (baud_start) begin
          state_d   = RUN;
          div_d     = sel_div;
          cont_d    = '0;
          bit_idx_d = '0;
        end
      end
      RUN: begin
        // An abort suppresses any tick that would have matched on this edge.
        if (!baud_start) begin
          state_d   = IDLE;
          cont_d    = '0;
          bit_idx_d = '0;
        end else begin
          mid_tick_d = at_half;
          if (at_end) begin
            bit_tick_d = 1'b1;
            cont_d     = '0;
            if (bit_idx_q == LAST_BIT) begin
              state_d      = DONE;
              bit_idx_d    = '0;
              frame_done_d = 1'b1;
            end else begin
              bit_idx_d = bit_idx_q + 4'd1;
            end
          end else begin
            cont_d = cont_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (!baud_start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cont_q       <= '0;
      div_q        <= '0;
      bit_idx_q    <= '0;
      mid_tick_q   <= 1'b0;
      bit_tick_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cont_q       <= cont_d;
      div_q        <= div_d;
      bit_idx_q    <= bit_idx_d;
      mid_tick_q   <= mid_tick_d;
      bit_tick_q   <= bit_tick_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign mid_tick   = mid_tick_q;
  assign bit_tick   = bit_tick_q;
  assign bit_idx    = bit_idx_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: table of rate selections, hand-written
// reset/abort/restart sequences and randomized frames against a timing model.
module tb_uart_baud_gen;

  localparam int CLK_FREQ = 50000000;
  localparam int CNT_W    = 16;
  localparam int FB       = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             baud_start = 1'b0;
  logic [2:0]       baud_sel = 3'd0;
  logic [CNT_W-1:0] custom_div = '0;
  logic             mid_tick, bit_tick, frame_done, busy;
  logic [3:0]       bit_idx;

  int checks = 0;
  int errors = 0;

  uart_baud_gen #(.CLK_FREQ(CLK_FREQ), .CNT_W(CNT_W), .FRAME_BITS(FB)) dut (
    .clk(clk), .rst_n(rst_n), .baud_start(baud_start), .baud_sel(baud_sel),
    .custom_div(custom_div), .mid_tick(mid_tick), .bit_tick(bit_tick),
    .bit_idx(bit_idx), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       sel;
    logic [CNT_W-1:0] cust;
    int               lim;
    int               exp_div;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference divisor straight from the rate table.
  function automatic int ref_div(input logic [2:0] sel, input int cust);
    case (sel)
      3'd1: return CLK_FREQ / 19200 - 1;
      3'd2: return CLK_FREQ / 38400 - 1;
      3'd3: return CLK_FREQ / 57600 - 1;
      3'd4: return CLK_FREQ / 115200 - 1;
      3'd7: return (cust < 3) ? 3 : cust;
      default: return CLK_FREQ / 9600 - 1;
    endcase
  endfunction

  // Expected outputs j cycles after the entry edge, with baud_start held high.
  function automatic void model(input int d, input int j, output logic m, output logic b,
                                output logic fd, output logic bs, output logic [3:0] idx);
    int p, h, n;
    p   = d + 1;
    h   = d / 2;
    n   = FB * p;
    bs  = (j < n);
    idx = (j < n) ? 4'(j / p) : 4'd0;
    b   = (j >= 1) && (j <= n) && (j % p == 0);
    fd  = (j == n);
    m   = (j >= h + 1) && (j <= (FB - 1) * p + h + 1) && ((j - h - 1) % p == 0);
  endfunction

  // Starts a frame from IDLE, compares every cycle up to lim (or just past the
  // frame end), then drops baud_start and expects a quiet IDLE.
  task automatic run_frame(input string tag, input int d, input int lim, input int sw_j,
                           input logic [2:0] sw_sel, input logic [CNT_W-1:0] sw_cust);
    int n, last, em, eb, ei, ed, es;
    logic m, b, fd, bs;
    logic [3:0] idx;
    n = FB * (d + 1);
    last = (lim < n + 3) ? lim : n + 3;
    em = 0; eb = 0; ei = 0; ed = 0; es = 0;
    baud_start = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      model(d, j, m, b, fd, bs, idx);
      if (mid_tick !== m) em++;
      if (bit_tick !== b) eb++;
      if (bit_idx !== idx) ei++;
      if (frame_done !== fd) ed++;
      if (busy !== bs) es++;
      if (j == sw_j) begin
        baud_sel   = sw_sel;
        custom_div = sw_cust;
      end
    end
    chk({tag, " mid_tick bad cycles"}, em, 0);
    chk({tag, " bit_tick bad cycles"}, eb, 0);
    chk({tag, " bit_idx bad cycles"}, ei, 0);
    chk({tag, " frame_done bad cycles"}, ed, 0);
    chk({tag, " busy bad cycles"}, es, 0);
    baud_start = 1'b0;
    @(negedge clk);
    chk({tag, " idle after stop"}, {mid_tick, bit_tick, bit_idx, frame_done, busy}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[12];
    int j;
    vecs[0]  = '{3'd1, 16'd0,   3910, 2603};
    vecs[1]  = '{3'd2, 16'd0,   1960, 1301};
    vecs[2]  = '{3'd3, 16'd0,   1310, 867};
    vecs[3]  = '{3'd4, 16'd0,   4400, 433};
    vecs[4]  = '{3'd5, 16'd0,   2610, 5207};
    vecs[5]  = '{3'd6, 16'd0,   2610, 5207};
    vecs[6]  = '{3'd7, 16'd1,   50,   3};
    vecs[7]  = '{3'd7, 16'd0,   50,   3};
    vecs[8]  = '{3'd7, 16'd2,   50,   3};
    vecs[9]  = '{3'd7, 16'd3,   50,   3};
    vecs[10] = '{3'd7, 16'd100, 1020, 100};
    vecs[11] = '{3'd7, 16'd4,   60,   4};

    #1;
    chk("reset outputs", {mid_tick, bit_tick, bit_idx, frame_done, busy}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle after reset release", {mid_tick, bit_tick, bit_idx, frame_done, busy}, 0);

    // 9600 frame; a switch to 115200 mid-frame must not alter the period.
    baud_sel = 3'd0;
    run_frame("sel0 with switch", 5207, 7815, 10, 3'd4, 16'd0);

    // Asynchronous reset in the middle of a 9600 frame.
    baud_sel = 3'd0;
    baud_start = 1'b1;
    repeat (3000) @(negedge clk);
    chk("busy before reset", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("outputs during async reset", {mid_tick, bit_tick, bit_idx, frame_done, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("after reset", 5207, 7815, -1, 3'd0, 16'd0);

    for (int i = 0; i < 12; i++) begin
      baud_sel   = vecs[i].sel;
      custom_div = vecs[i].cust;
      run_frame($sformatf("vec%0d", i), vecs[i].exp_div, vecs[i].lim, -1, 3'd0, 16'd0);
    end

    baud_sel = 3'd7;
    custom_div = 16'd100;
    run_frame("custom100 ignore change", 100, 2000, 50, 3'd4, 16'd20);
    run_frame("next frame sel4", 433, 5000, -1, 3'd0, 16'd0);

    // Abort at bit 3 on the edge where the counter sits at the half point.
    baud_sel = 3'd4;
    run_frame("abort bit3 half", 433, 3 * 434 + 216, -1, 3'd0, 16'd0);
    run_frame("restart after abort", 433, 5000, -1, 3'd0, 16'd0);

    // Hold start until frame_done, then a one-cycle low re-arms the block.
    baud_sel = 3'd7;
    custom_div = 16'd5;
    baud_start = 1'b1;
    @(posedge clk);
    for (j = 0; j < 200; j++) begin
      @(negedge clk);
      if (frame_done === 1'b1) break;
    end
    chk("cycles to frame_done custom5", j, 60);
    chk("busy with frame_done", {busy, bit_tick}, 2'b01);
    repeat (3) @(negedge clk);
    chk("no restart while held", {busy, mid_tick, bit_tick}, 0);
    baud_start = 1'b0;
    @(negedge clk);
    chk("idle after release", busy, 0);
    baud_start = 1'b1;
    @(negedge clk);
    chk("rerun after one low cycle", {busy, bit_idx}, 5'b10000);
    baud_start = 1'b0;
    @(negedge clk);
    chk("abort leaves idle", busy, 0);

    for (int r = 0; r < 10; r++) begin
      int d, lim, sw;
      baud_sel   = 3'($urandom_range(0, 7));
      custom_div = CNT_W'($urandom_range(0, 40));
      d = ref_div(baud_sel, int'(custom_div));
      lim = (d > 100) ? int'($urandom_range(0, 700)) : int'($urandom_range(0, FB * (d + 1) + 3));
      sw = int'($urandom_range(0, lim));
      run_frame($sformatf("rand%0d", r), d, lim, sw, 3'($urandom_range(0, 7)),
                CNT_W'($urandom_range(0, 40)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
